patch_stream_scheduler: RTL and testbench

//  Sequences one patchifier instance per frame: accepts a frame request, pulses the patchifier enable and

---
 rtl/patch_stream_scheduler_pkg.sv | 26 ++
 rtl/patch_stream_scheduler_watchdog.sv | 33 +++
 rtl/patch_stream_scheduler.sv | 153 +++++++++++++++
 tb/tb_patch_stream_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/patch_stream_scheduler_pkg.sv
// vit_pkg: types and defaults shared by the patch stream scheduler and its watchdog.
//   pf_state_e    : patchifier state encoding as seen on the pf_state port (3 bits)
//   sched_state_e : scheduler FSM states
//   TOTAL_NUM_PATCHES_DEF : default patches per frame, matches the patchifier
package vit_pkg;

  localparam int TOTAL_NUM_PATCHES_DEF = 16;

  typedef enum logic [2:0] {
    PF_IDLE = 3'd0,
    PF_PRE  = 3'd1,
    PF_PROC = 3'd2,
    PF_POST = 3'd3,
    PF_DONE = 3'd4
  } pf_state_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT    = 3'd2,
    S_STREAM  = 3'd3,
    S_RELEASE = 3'd4,
    S_ERR     = 3'd5
  } sched_state_e;

endpackage

// File: rtl/patch_stream_scheduler_watchdog.sv
// sched_watchdog: load-clear up-counter with enable and an expired flag.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : zeroes the counter (has priority over en)
//   en         : count this cycle
//   expired    : high in the cycle that would count the LIMIT-th enabled cycle
// The counter saturates at LIMIT-1 so it never wraps while the owner lingers.
module sched_watchdog #(
  parameter int CNT_W = 16,
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] count;
  logic             at_limit;

  assign at_limit = (count == CNT_W'(LIMIT - 1));
  assign expired  = en && at_limit;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en && !at_limit) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/patch_stream_scheduler.sv
// patch_stream_scheduler: per-frame sequencer for one patchifier.
//   Accepts a frame request, enables the patchifier, waits for DONE, streams the
//   patch tokens downstream one per valid/ready handshake, then releases the
//   patchifier. A watchdog bounds the enable-to-DONE time.
// Optional build macro: VIT_CLS_TOKEN_EN prepends a class token (idx 0, tok_is_cls=1)
//   to every frame, giving TOTAL_NUM_PATCHES+1 tokens.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   frame_valid/ready: frame request handshake (ready only when idle and patchifier idle)
//   pf_en            : patchifier enable, high while in S_START
//   pf_state         : patchifier state code (codes 5-7 are neither IDLE nor DONE)
//   pf_output_taken  : patchifier release, high while in S_RELEASE
//   patch_valid/ready: token handshake; patch_idx, patch_last, tok_is_cls qualify it
//   frame_done       : one-cycle pulse after the patchifier returns to idle
//   busy             : scheduler not idle
//   err_timeout      : sticky watchdog error, cleared by err_clear
//   frame_count      : completed frames, wrapping
module patch_stream_scheduler
  import vit_pkg::*;
#(
  parameter int TOTAL_NUM_PATCHES = TOTAL_NUM_PATCHES_DEF,
  parameter int PATCH_IDX_W       = 4,
  parameter int TIMEOUT_CYCLES    = 1024,
  parameter int CNT_W             = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_valid,
  output logic                   frame_ready,
  output logic                   pf_en,
  input  logic [2:0]             pf_state,
  output logic                   pf_output_taken,
  output logic                   patch_valid,
  input  logic                   patch_ready,
  output logic [PATCH_IDX_W-1:0] patch_idx,
  output logic                   patch_last,
  output logic                   tok_is_cls,
  output logic                   frame_done,
  output logic                   busy,
  output logic                   err_timeout,
  input  logic                   err_clear,
  output logic [CNT_W-1:0]       frame_count
);

  localparam int TOK_W = PATCH_IDX_W + 1;
`ifdef VIT_CLS_TOKEN_EN
  localparam int NUM_TOK = TOTAL_NUM_PATCHES + 1;
`else
  localparam int NUM_TOK = TOTAL_NUM_PATCHES;
`endif

  sched_state_e     state, next_state;
  logic [TOK_W-1:0] tok_cnt;
  logic             pf_is_idle, pf_is_done;
  logic             last_tok, handshake, release_done;
  logic             wd_clear, wd_en, wd_expired;

  assign pf_is_idle = (pf_state == PF_IDLE);
  assign pf_is_done = (pf_state == PF_DONE);

  assign frame_ready     = (state == S_IDLE) && pf_is_idle;
  assign busy            = (state != S_IDLE);
  assign pf_en           = (state == S_START);
  assign pf_output_taken = (state == S_RELEASE);
  assign patch_valid     = (state == S_STREAM);
  assign err_timeout     = (state == S_ERR);

  assign last_tok     = (tok_cnt == TOK_W'(NUM_TOK - 1));
  assign handshake    = patch_valid && patch_ready;
  assign release_done = (state == S_RELEASE) && pf_is_idle;
  assign patch_last   = patch_valid && last_tok;

  // Token qualifiers are forced to zero outside streaming so idle outputs stay quiet.
`ifdef VIT_CLS_TOKEN_EN
  assign tok_is_cls = patch_valid && (tok_cnt == '0);
  assign patch_idx  = (!patch_valid || tok_cnt == '0) ? '0
                                                      : PATCH_IDX_W'(tok_cnt - TOK_W'(1));
`else
  assign tok_is_cls = 1'b0;
  assign patch_idx  = patch_valid ? PATCH_IDX_W'(tok_cnt) : '0;
`endif

  assign wd_clear = (state == S_IDLE);
  assign wd_en    = (state == S_START) || (state == S_WAIT);

  sched_watchdog #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // DONE is checked before watchdog expiry so a patchifier finishing on the
  // last allowed cycle still gets streamed.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (frame_valid && frame_ready) next_state = S_START;
      end
      S_START: begin
        if (pf_is_done)      next_state = S_WAIT;
        else if (wd_expired) next_state = S_ERR;
        else if (!pf_is_idle) next_state = S_WAIT;
      end
      S_WAIT: begin
        if (pf_is_done)      next_state = S_STREAM;
        else if (wd_expired) next_state = S_ERR;
      end
      S_STREAM: begin
        if (handshake && last_tok) next_state = S_RELEASE;
      end
      S_RELEASE: begin
        if (pf_is_idle) next_state = S_IDLE;
      end
      S_ERR: begin
        if (err_clear) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tok_cnt     <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      if (state == S_WAIT) begin
        tok_cnt <= '0;
      end else if (handshake) begin
        tok_cnt <= tok_cnt + TOK_W'(1);
      end
      frame_done <= release_done;
      if (release_done) begin
        frame_count <= frame_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_patch_stream_scheduler.sv
// Self-checking bench for patch_stream_scheduler. Models the patchifier (DONE ten
// cycles after enable, or stuck in PROC) and checks the token stream, frame
// completion and error behaviour against a token/frame level reference.
module tb_patch_stream_scheduler;

  localparam int NP    = 16;
  localparam int IDX_W = 4;
  localparam int CW    = 16;
  localparam int TMO   = 32;
`ifdef VIT_CLS_TOKEN_EN
  localparam int NT  = NP + 1;
  localparam int CLS = 1;
`else
  localparam int NT  = NP;
  localparam int CLS = 0;
`endif

  logic             clk = 1'b0;
  logic             reset, frame_valid, frame_ready, pf_en, pf_output_taken;
  logic [2:0]       pf_state;
  logic             patch_valid, patch_ready, patch_last, tok_is_cls;
  logic [IDX_W-1:0] patch_idx;
  logic             frame_done, busy, err_timeout, err_clear;
  logic [CW-1:0]    frame_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit stuck    = 1'b0;
  int pf_cnt   = 0;

  // Reference state kept by the monitor.
  int tok = 0, pend = 0, exp_fc = 0, hs_total = 0, frames_streamed = 0, done_cnt = 0;
  bit prev_stall = 1'b0;
  int prev_idx   = 0;

  patch_stream_scheduler #(
    .TOTAL_NUM_PATCHES (NP),
    .PATCH_IDX_W       (IDX_W),
    .TIMEOUT_CYCLES    (TMO),
    .CNT_W             (CW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .frame_valid     (frame_valid),
    .frame_ready     (frame_ready),
    .pf_en           (pf_en),
    .pf_state        (pf_state),
    .pf_output_taken (pf_output_taken),
    .patch_valid     (patch_valid),
    .patch_ready     (patch_ready),
    .patch_idx       (patch_idx),
    .patch_last      (patch_last),
    .tok_is_cls      (tok_is_cls),
    .frame_done      (frame_done),
    .busy            (busy),
    .err_timeout     (err_timeout),
    .err_clear       (err_clear),
    .frame_count     (frame_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Patchifier model: IDLE -en-> PRE(1..3) PROC(4..8) POST(9) DONE(10) -taken-> IDLE.
  always @(posedge clk) begin
    if (reset) begin
      pf_state <= 3'd0;
      pf_cnt   <= 0;
    end else begin
      case (pf_state)
        3'd0: if (pf_en) begin pf_state <= 3'd1; pf_cnt <= 1; end
        3'd4: if (pf_output_taken) begin pf_state <= 3'd0; pf_cnt <= 0; end
        default: begin
          pf_cnt <= pf_cnt + 1;
          if (stuck && pf_cnt >= 3)  pf_state <= 3'd2;
          else if (pf_cnt + 1 <= 3)  pf_state <= 3'd1;
          else if (pf_cnt + 1 <= 8)  pf_state <= 3'd2;
          else if (pf_cnt + 1 == 9)  pf_state <= 3'd3;
          else                       pf_state <= 3'd4;
        end
      endcase
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ref_idx(input int t);
    if (CLS != 0) return (t == 0) ? 0 : t - 1;
    return t;
  endfunction

  function automatic int ref_cls(input int t);
    return (CLS != 0 && t == 0) ? 1 : 0;
  endfunction

  // Per-cycle reference checks, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      tok = 0; pend = 0; exp_fc = 0; prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", patch_valid, 1);
        check("stall_idx_held", patch_idx, prev_idx);
      end
      if (patch_valid) begin
        check("tok_idx", patch_idx, ref_idx(tok));
        check("tok_last", patch_last, (tok == NT - 1) ? 1 : 0);
        check("tok_cls", tok_is_cls, ref_cls(tok));
      end else begin
        check("idle_last", patch_last, 0);
      end
      if (busy) check("ready_while_busy", frame_ready, 0);
      else      check("idle_handshake_outs", {pf_en, pf_output_taken, patch_valid}, 0);
      if (patch_valid && patch_ready) begin
        hs_total++;
        if (tok == NT - 1) begin
          tok = 0; pend++; frames_streamed++;
        end else begin
          tok++;
        end
      end
      prev_stall = patch_valid && !patch_ready;
      prev_idx   = patch_idx;
      if (frame_done) begin
        check("frame_done_has_frame", (pend > 0) ? 1 : 0, 1);
        if (pend > 0) pend--;
        exp_fc = (exp_fc + 1) % (1 << CW);
        done_cnt++;
        check("frame_count", frame_count, exp_fc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string name);
    check({name, "_pf_en"}, pf_en, 0);
    check({name, "_taken"}, pf_output_taken, 0);
    check({name, "_valid"}, patch_valid, 0);
    check({name, "_idx"}, patch_idx, 0);
    check({name, "_last"}, patch_last, 0);
    check({name, "_cls"}, tok_is_cls, 0);
    check({name, "_done"}, frame_done, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_err"}, err_timeout, 0);
    check({name, "_count"}, frame_count, 0);
    check({name, "_ready"}, frame_ready, 1);
  endtask

  initial begin
    int t_en, first_hs, last_hs, done_c, n_hs, first_idx, first_cls, last_idx, base, en_rises, t_err;
    bit seen, prev_en;
    reset = 1'b1; frame_valid = 1'b0; patch_ready = 1'b0; err_clear = 1'b0;
    repeat (3) tick();
    check_quiet("reset");
    reset = 1'b0;
    tick();

    // Nominal frame, downstream always ready.
    patch_ready = 1'b1;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    t_en = -1; first_hs = -1; last_hs = -1; done_c = -1; n_hs = 0;
    first_idx = -1; first_cls = -1; last_idx = -1;
    for (int i = 0; i < 80; i++) begin
      if (pf_en && t_en < 0) t_en = cyc;
      if (patch_valid && patch_ready) begin
        if (first_hs < 0) begin first_hs = cyc; first_idx = patch_idx; first_cls = tok_is_cls; end
        last_hs = cyc; n_hs++;
        if (patch_last) last_idx = patch_idx;
      end
      if (frame_done) begin done_c = cyc; break; end
      tick();
    end
    check("nom_first_hs_latency", first_hs - t_en, 11);
    check("nom_last_hs_latency", last_hs - t_en, 10 + NT);
    check("nom_done_latency", done_c - t_en, 13 + NT);
    check("nom_hs_count", n_hs, NT);
    check("nom_hs_back_to_back", last_hs - first_hs, NT - 1);
    check("nom_first_idx", first_idx, 0);
    check("nom_first_cls", first_cls, CLS);
    check("nom_last_idx", last_idx, 15);
    check("nom_frame_count", frame_count, 1);
    tick();
    check("nom_done_one_cycle", frame_done, 0);

    // Backpressure: ready toggling, then random ready with err_clear noise.
    for (int f = 0; f < 3; f++) begin
      base = hs_total;
      done_c = done_cnt;
      patch_ready = 1'b0;
      frame_valid = 1'b1;
      tick();
      frame_valid = 1'b0;
      for (int i = 0; i < 300 && done_cnt == done_c; i++) begin
        if (f == 0) patch_ready = ~patch_ready;
        else begin
          patch_ready = 1'($urandom_range(0, 1));
          err_clear   = 1'($urandom_range(0, 1));
        end
        tick();
      end
      err_clear = 1'b0;
      check("bp_frame_done", done_cnt, done_c + 1);
      check("bp_hs_count", hs_total - base, NT);
    end
    patch_ready = 1'b1;
    check("bp_frame_count", frame_count, 4);

    // Reset in the middle of the stream.
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (patch_valid && patch_ready && patch_idx == 4'd7) begin
        reset = 1'b1; seen = 1'b1; break;
      end
      tick();
    end
    check("rst_reached_hs7", seen, 1);
    tick();
    check_quiet("rst_mid");
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("rst_no_done", frame_done, 0);
    end

    // Back-to-back frames with frame_valid held high.
    base = frames_streamed;
    done_c = done_cnt;
    en_rises = 0; prev_en = 1'b0;
    frame_valid = 1'b1;
    for (int i = 0; i < 400 && done_cnt < done_c + 3; i++) begin
      tick();
      if (pf_en && !prev_en) en_rises++;
      prev_en = pf_en;
      if (frames_streamed >= base + 3) frame_valid = 1'b0;
    end
    frame_valid = 1'b0;
    check("b2b_done_pulses", done_cnt - done_c, 3);
    check("b2b_frame_count", frame_count, 3);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pf_en && !prev_en) en_rises++;
      prev_en = pf_en;
    end
    check("b2b_accepts", en_rises, 3);

    // Watchdog: patchifier stuck in PROC.
    stuck = 1'b1;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    t_en = -1; t_err = -1;
    for (int i = 0; i < 100; i++) begin
      if (pf_en && t_en < 0) t_en = cyc;
      if (err_timeout) begin t_err = cyc; break; end
      tick();
    end
    check("tmo_latency", t_err - t_en, TMO);
    check("tmo_frame_ready", frame_ready, 0);
    check("tmo_busy", busy, 1);
    check("tmo_outs", {pf_en, pf_output_taken, patch_valid}, 0);
    frame_valid = 1'b1;
    repeat (5) tick();
    check("tmo_sticky", err_timeout, 1);
    check("tmo_ignore_frame", pf_en, 0);
    frame_valid = 1'b0;
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check("tmo_clear_busy", busy, 0);
    check("tmo_clear_err", err_timeout, 0);
    check("tmo_pf_not_idle_ready", frame_ready, 0);
    reset = 1'b1;
    stuck = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    check("tmo_recover_ready", frame_ready, 1);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "bench time limit");
  end

endmodule
